// File: rtl/dsm_dac_mc.sv
// Multi-channel delta-sigma 1-bit DAC modulator, order 1 or 2.
// A sample word arrives on a valid/ready handshake and is staged in a one-deep holding
// buffer. It becomes the active modulator input at the next sample tick, which occurs
// once every 2^OSR clocks. Both integrators saturate instead of wrapping, and any
// saturation sets a sticky per-channel clip flag.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   s_valid   sample word valid
//   s_ready   holding buffer can accept (combinational)
//   s_data    CH two's-complement samples, channel k at [k*DAC_BW +: DAC_BW]
//   mute      forces zero input, sampled at the sample tick
//   clr_clip  clears all clip flags (a saturation in the same cycle wins)
//   dout      registered 1-bit modulator outputs
//   clip      sticky saturation flags
//   underrun  one-cycle pulse after a tick that found no new sample
module dsm_dac_mc #(
  parameter int unsigned CH     = 2,
  parameter int unsigned DAC_BW = 16,
  parameter int unsigned OSR    = 6,
  parameter int unsigned ORDER  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH*DAC_BW-1:0] s_data,
  input  logic                 mute,
  input  logic                 clr_clip,
  output logic [CH-1:0]        dout,
  output logic [CH-1:0]        clip,
  output logic                 underrun
);

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("dsm_dac_mc: ORDER must be 1 or 2");
  end

  localparam int unsigned A1W = DAC_BW + 2;
  localparam int unsigned A2W = DAC_BW + 2 + OSR;
  // Headroom so acc2 + s1 - y never overflows before clamping.
  localparam int unsigned SW  = A2W + 2;

  localparam logic [OSR-1:0]       PhMax = '1;
  localparam logic signed [SW-1:0] Fb    = (SW'(1) << (DAC_BW - 1)) + (SW'(1) << (OSR + 2));
  localparam logic signed [SW-1:0] A1Max = (SW'(1) << (A1W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] A1Min = ~A1Max;
  localparam logic signed [SW-1:0] A2Max = (SW'(1) << (A2W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] A2Min = ~A2Max;

  logic [OSR-1:0]          ph_q, ph_d;
  logic [CH*DAC_BW-1:0]    buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [CH*DAC_BW-1:0]    act_q, act_d;
  logic                    mute_q, mute_d;
  logic                    underrun_q, underrun_d;
  logic [CH-1:0][A1W-1:0]  acc1_q, acc1_d;
  logic [CH-1:0][A2W-1:0]  acc2_q, acc2_d;
  logic [CH-1:0]           dout_q, dout_d;
  logic [CH-1:0]           clip_q, clip_d;

  logic tick;
  logic xfer;

  assign tick    = (ph_q == PhMax);
  assign s_ready = !buf_full_q || tick;
  assign xfer    = s_valid && s_ready;

  // Holding buffer / active sample sequencing.
  always_comb begin
    ph_d       = ph_q + 1'b1;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    act_d      = act_q;
    mute_d     = mute_q;
    underrun_d = 1'b0;
    if (tick) begin
      mute_d = mute;
      if (buf_full_q) begin
        act_d = buf_q;
        if (xfer) begin
          buf_d = s_data;
        end else begin
          buf_full_d = 1'b0;
        end
      end else if (xfer) begin
        act_d = s_data;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (xfer) begin
      buf_d      = s_data;
      buf_full_d = 1'b1;
    end
  end

  // Per-channel modulator datapath.
  always_comb begin : p_mod
    logic signed [SW-1:0] x, y, sum1, s1, sum2, s2;
    logic                 sat1, sat2;
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    dout_d = dout_q;
    clip_d = clip_q;
    for (int k = 0; k < CH; k++) begin
      if (mute_q) begin
        x = '0;
      end else begin
        x = SW'(signed'(act_q[k*DAC_BW +: DAC_BW]));
      end
      y = dout_q[k] ? Fb : -Fb;

      sum1 = SW'(signed'(acc1_q[k])) + x - y;
      sat1 = 1'b1;
      if (sum1 > A1Max) begin
        s1 = A1Max;
      end else if (sum1 < A1Min) begin
        s1 = A1Min;
      end else begin
        s1   = sum1;
        sat1 = 1'b0;
      end

      sum2 = SW'(signed'(acc2_q[k])) + s1 - y;
      sat2 = 1'b1;
      if (sum2 > A2Max) begin
        s2 = A2Max;
      end else if (sum2 < A2Min) begin
        s2 = A2Min;
      end else begin
        s2   = sum2;
        sat2 = 1'b0;
      end

      acc1_d[k] = s1[A1W-1:0];
      if (ORDER == 2) begin
        acc2_d[k] = s2[A2W-1:0];
        dout_d[k] = !s2[SW-1];
      end else begin
        acc2_d[k] = '0;
        dout_d[k] = !s1[SW-1];
      end
      clip_d[k] = sat1 || ((ORDER == 2) && sat2) || (clip_q[k] && !clr_clip);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      act_q      <= '0;
      mute_q     <= 1'b0;
      underrun_q <= 1'b0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      dout_q     <= '0;
      clip_q     <= '0;
    end else begin
      ph_q       <= ph_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      act_q      <= act_d;
      mute_q     <= mute_d;
      underrun_q <= underrun_d;
      acc1_q     <= acc1_d;
      acc2_q     <= acc2_d;
      dout_q     <= dout_d;
      clip_q     <= clip_d;
    end
  end

  assign dout     = dout_q;
  assign clip     = clip_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dsm_dac_mc.sv
// Self-checking bench for dsm_dac_mc. Three instances: the default configuration
// (2 ch, 16 bit, OSR 6, order 2) and two narrow single-channel ones (8 bit, OSR 2,
// order 1 and order 2) that are driven hard enough to exercise saturation.
// A behavioural model advances on each rising edge and pushes the expected outputs to a
// scoreboard queue; the queue is popped and compared on the following falling edge.
module tb_dsm_dac_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       mute = 1'b0;
  logic       clr_clip = 1'b0;
  logic [2:0] vld = 3'b000;
  longint     word [3][2];

  logic [31:0] sd0;
  logic [7:0]  sd1, sd2;
  assign sd0 = {word[0][1][15:0], word[0][0][15:0]};
  assign sd1 = word[1][0][7:0];
  assign sd2 = word[2][0][7:0];

  logic       rdy0, rdy1, rdy2;
  logic [1:0] dout0, clip0;
  logic       dout1, clip1, dout2, clip2;
  logic       ur0, ur1, ur2;

  dsm_dac_mc #(.CH(2), .DAC_BW(16), .OSR(6), .ORDER(2)) u_dut (
    .clk(clk), .rst(rst), .s_valid(vld[0]), .s_ready(rdy0), .s_data(sd0), .mute(mute),
    .clr_clip(clr_clip), .dout(dout0), .clip(clip0), .underrun(ur0)
  );
  dsm_dac_mc #(.CH(1), .DAC_BW(8), .OSR(2), .ORDER(1)) u_o1 (
    .clk(clk), .rst(rst), .s_valid(vld[1]), .s_ready(rdy1), .s_data(sd1), .mute(mute),
    .clr_clip(clr_clip), .dout(dout1), .clip(clip1), .underrun(ur1)
  );
  dsm_dac_mc #(.CH(1), .DAC_BW(8), .OSR(2), .ORDER(2)) u_o2 (
    .clk(clk), .rst(rst), .s_valid(vld[2]), .s_ready(rdy2), .s_data(sd2), .mute(mute),
    .clr_clip(clr_clip), .dout(dout2), .clip(clip2), .underrun(ur2)
  );

  // Model configuration per instance.
  int bw   [3] = '{16, 8, 8};
  int osr  [3] = '{6, 2, 2};
  int ordr [3] = '{2, 1, 2};
  int nch  [3] = '{2, 1, 1};

  // Model state.
  int     m_ph [3];
  bit     m_bf [3], m_mr [3], m_ur [3], m_xf [3];
  longint m_act [3][2], m_buf [3][2], m_a1 [3][2], m_a2 [3][2];
  bit     m_d [3][2], m_clp [3][2];

  // Stimulus controls.
  bit     rnd [3];
  longint lvl [3][2];
  bit     clr_en = 1'b0;

  typedef struct packed {
    bit [1:0] d0, c0;
    bit u0, r0, d1, c1, u1, r1, d2, c2, u2, r2;
  } exp_t;
  exp_t sbq [$];
  exp_t e_push;

  int n_vec = 0;
  int n_err = 0;
  int cnt0, cnt1, ucnt;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    longint fb, m1, m2, x, y, s1, s2;
    bit     sat, tick;
    int     pmax;
    if (rst) begin
      m_ph[i] = 0; m_bf[i] = 0; m_mr[i] = 0; m_ur[i] = 0; m_xf[i] = 0;
      for (int k = 0; k < 2; k++) begin
        m_act[i][k] = 0; m_buf[i][k] = 0; m_a1[i][k] = 0; m_a2[i][k] = 0;
        m_d[i][k] = 0; m_clp[i][k] = 0;
      end
      return;
    end
    pmax = (1 << osr[i]) - 1;
    tick = (m_ph[i] == pmax);
    m_xf[i] = vld[i] && (!m_bf[i] || tick);
    for (int k = 0; k < nch[i]; k++) begin
      x  = m_mr[i] ? 0 : m_act[i][k];
      fb = (longint'(1) << (bw[i] - 1)) + (longint'(1) << (osr[i] + 2));
      y  = m_d[i][k] ? fb : -fb;
      sat = 0;
      m1 = (longint'(1) << (bw[i] + 1)) - 1;
      s1 = m_a1[i][k] + x - y;
      if (s1 > m1) begin s1 = m1; sat = 1; end
      else if (s1 < -m1 - 1) begin s1 = -m1 - 1; sat = 1; end
      if (ordr[i] == 2) begin
        m2 = (longint'(1) << (bw[i] + 1 + osr[i])) - 1;
        s2 = m_a2[i][k] + s1 - y;
        if (s2 > m2) begin s2 = m2; sat = 1; end
        else if (s2 < -m2 - 1) begin s2 = -m2 - 1; sat = 1; end
        m_a2[i][k] = s2;
        m_d[i][k]  = (s2 >= 0);
      end else begin
        m_d[i][k] = (s1 >= 0);
      end
      m_a1[i][k]  = s1;
      m_clp[i][k] = sat || (m_clp[i][k] && !clr_clip);
    end
    m_ur[i] = 0;
    if (tick) begin
      m_mr[i] = mute;
      if (m_bf[i]) begin
        for (int k = 0; k < 2; k++) m_act[i][k] = m_buf[i][k];
        if (m_xf[i]) for (int k = 0; k < 2; k++) m_buf[i][k] = word[i][k];
        else m_bf[i] = 0;
      end else if (m_xf[i]) begin
        for (int k = 0; k < 2; k++) m_act[i][k] = word[i][k];
      end else begin
        m_ur[i] = 1;
      end
    end else if (m_xf[i]) begin
      for (int k = 0; k < 2; k++) m_buf[i][k] = word[i][k];
      m_bf[i] = 1;
    end
    m_ph[i] = (m_ph[i] + 1) & pmax;
  endtask

  function automatic bit m_rdy(input int i);
    return !m_bf[i] || (m_ph[i] == (1 << osr[i]) - 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
    e_push.d0 = {m_d[0][1], m_d[0][0]};
    e_push.c0 = {m_clp[0][1], m_clp[0][0]};
    e_push.u0 = m_ur[0]; e_push.r0 = m_rdy(0);
    e_push.d1 = m_d[1][0]; e_push.c1 = m_clp[1][0];
    e_push.u1 = m_ur[1]; e_push.r1 = m_rdy(1);
    e_push.d2 = m_d[2][0]; e_push.c2 = m_clp[2][0];
    e_push.u2 = m_ur[2]; e_push.r2 = m_rdy(2);
    sbq.push_back(e_push);
  end

  function automatic longint gen(input int i, input int k);
    if (rnd[i])
      return longint'($urandom_range(0, (1 << bw[i]) - 1)) - (longint'(1) << (bw[i] - 1));
    return lvl[i][k];
  endfunction

  // Advance a channel's word only once it has been taken (or while invalid).
  task automatic drive();
    clr_clip = clr_en && ($urandom_range(0, 49) == 0);
    for (int i = 0; i < 3; i++)
      if (m_xf[i] || !vld[i])
        for (int k = 0; k < 2; k++) word[i][k] = gen(i, k);
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("dout0", dout0, e.d0);    chk("clip0", clip0, e.c0);
        chk("underrun0", ur0, e.u0);  chk("s_ready0", rdy0, e.r0);
        chk("dout1", dout1, e.d1);    chk("clip1", clip1, e.c1);
        chk("underrun1", ur1, e.u1);  chk("s_ready1", rdy1, e.r1);
        chk("dout2", dout2, e.d2);    chk("clip2", clip2, e.c2);
        chk("underrun2", ur2, e.u2);  chk("s_ready2", rdy2, e.r2);
      end
      cnt0 += dout0[0];
      cnt1 += dout0[1];
      ucnt += ur0;
      drive();
    end
  endtask

  task automatic wait_ph(input int i, input int t);
    for (int c = 0; c < 300 && m_ph[i] != t; c++) step(1);
    chk("wait_ph", m_ph[i], t);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rnd[i] = 0;
      for (int k = 0; k < 2; k++) begin lvl[i][k] = 0; word[i][k] = 0; end
    end
    // Reset, stream zeros, then reset again mid-stream.
    step(2);
    rst = 1'b0;
    vld = 3'b111;
    step(150);
    rst = 1'b1;
    step(3);
    chk("rst_dout", dout0, 0);
    chk("rst_ready", rdy0, 1);
    rst = 1'b0;
    step(300);

    // Zero input density.
    cnt0 = 0; cnt1 = 0;
    step(4096);
    chk($sformatf("zero_dens0 cnt=%0d", cnt0), (cnt0 >= 2046 && cnt0 <= 2050), 1);
    chk($sformatf("zero_dens1 cnt=%0d", cnt1), (cnt1 >= 2046 && cnt1 <= 2050), 1);

    // Full-scale density.
    lvl[0][0] = 32767; lvl[0][1] = -32768;
    step(512);
    cnt0 = 0; cnt1 = 0;
    step(4096);
    chk($sformatf("fs_dens0 cnt=%0d", cnt0), (cnt0 >= 4076 && cnt0 <= 4084), 1);
    chk($sformatf("fs_dens1 cnt=%0d", cnt1), (cnt1 >= 12 && cnt1 <= 20), 1);

    // Handshake from ph=10 with distinct words, then mute mid-period.
    rnd[0] = 1;
    vld[0] = 1'b0;
    step(70);
    wait_ph(0, 10);
    vld[0] = 1'b1;
    step(200);
    lvl[0][0] = 16384; lvl[0][1] = 16384; rnd[0] = 0;
    step(130);
    wait_ph(0, 20);
    mute = 1'b1;
    step(200);
    mute = 1'b0;
    step(130);

    // Underrun: withhold valid across two ticks starting right after a tick.
    rnd[0] = 1;
    wait_ph(0, 1);
    ucnt = 0;
    vld[0] = 1'b0;
    step(128);
    vld[0] = 1'b1;
    step(2);
    chk("underrun_count", ucnt, 1);

    // Drive the narrow instances hard, with occasional clip clears.
    clr_en = 1'b1;
    lvl[1][0] = 127;  lvl[2][0] = 127;
    step(600);
    lvl[1][0] = -128; lvl[2][0] = -128;
    step(600);
    rnd[1] = 1; rnd[2] = 1;
    step(800);
    clr_en = 1'b0;
    rnd[1] = 0; rnd[2] = 0;
    lvl[1][0] = 0; lvl[2][0] = 0;
    step(100);

    // Reset with a buffered sample pending.
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
